mem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port program/data memory of the accumulator CPU. It shares the memory between the CPU controller (instruction fetch, LDA operand read, STA write) and a host loader port that writes programs and reads back memory. It runs each granted transaction as a fixed multi-cycle memory sequence: read/enable, transfer, done. Round-robin priority prevents either side from starving the other.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: sequencer states, requester IDs, default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        XF   = 3'd2,
        WR   = 3'd3,
        DN   = 3'd4
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_LD  = 1'b1;

    // First sequencer state of a granted transaction.
    function automatic state_e first_state(input logic we);
        return we ? WR : RD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter view, master the environment view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_done;
    logic [DATA_W-1:0] ld_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_xfer;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        output ld_gnt, ld_done, ld_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_xfer, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        input  ld_gnt, ld_done, ld_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_xfer, mem_we
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = REQ_CPU;
        if (&req) begin
            winner = ~last;
        end else if (req[REQ_LD]) begin
            winner = REQ_LD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU and loader; reads take 3 cycles from sampling, writes 2.
// A requester holds req until its done pulse; the loser of a tie waits and wins the next IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              CLR,
    mem_port_arbiter_if.slave bus
);

    typedef struct packed {
        req_id_t           owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    state_e            state_q, state_d;
    txn_t              txn_q, txn_d;
    req_id_t           last_q, last_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

    req_id_t pick_winner;
    logic    pick_any;
    logic    active;

    rr_pick2 u_pick (
        .req    ({bus.ld_req, bus.cpu_req}),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Pointer resets to the loader so the CPU wins the first tie.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            last_q      <= REQ_LD;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            last_q      <= last_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        last_d      = last_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    txn_d.owner = pick_winner;
                    if (pick_winner == REQ_LD) begin
                        txn_d.we    = bus.ld_we;
                        txn_d.addr  = bus.ld_addr;
                        txn_d.wdata = bus.ld_wdata;
                    end else begin
                        txn_d.we    = bus.cpu_we;
                        txn_d.addr  = bus.cpu_addr;
                        txn_d.wdata = bus.cpu_wdata;
                    end
                    state_d = first_state(txn_d.we);
                end
            end
            RD: state_d = XF;
            XF: begin
                if (txn_q.owner == REQ_LD) begin
                    ld_rdata_d = bus.mem_rdata;
                end else begin
                    cpu_rdata_d = bus.mem_rdata;
                end
                state_d = DN;
            end
            WR: state_d = DN;
            DN: begin
                last_d  = txn_q.owner;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode from registered state only, so reset drops every strobe immediately.
    assign active        = (state_q != IDLE);
    assign bus.cpu_gnt   = active && (txn_q.owner == REQ_CPU);
    assign bus.ld_gnt    = active && (txn_q.owner == REQ_LD);
    assign bus.cpu_done  = (state_q == DN) && (txn_q.owner == REQ_CPU);
    assign bus.ld_done   = (state_q == DN) && (txn_q.owner == REQ_LD);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ld_rdata  = ld_rdata_q;
    assign bus.mem_addr  = active ? txn_q.addr : '0;
    assign bus.mem_wdata = active ? txn_q.wdata : '0;
    assign bus.mem_rd    = (state_q == RD);
    assign bus.mem_xfer  = (state_q == XF);
    assign bus.mem_we    = (state_q == WR);

    a_gnt_excl: assert property (@(posedge clk) disable iff (CLR)
        !(bus.cpu_gnt && bus.ld_gnt));
    a_strobe_excl: assert property (@(posedge clk) disable iff (CLR)
        $onehot0({bus.mem_rd, bus.mem_xfer, bus.mem_we}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model and memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         wiggle;
        bit         abort;
    } item_t;

    logic clk = 1'b0;
    logic CLR;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .CLR(CLR), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit run_cmp  = 1'b0;

    logic [7:0] env_mem   [256];
    logic [7:0] model_mem [256];

    item_t q_cpu[$];
    item_t q_ld[$];
    bit    busy  [2];
    int    a_cyc [2];
    int    d_cyc [2];
    bit    done_log[$];
    bit    ld_gnt_seen;
    int    we_cycles;

    // model state
    bit         m_active = 1'b0;
    bit         m_own, m_we, m_last = 1'b1;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_rdata [2];
    int         m_start, t;
    bit         e_rd, e_xf, e_we, e_done;
    logic [7:0] e_addr, e_wdata;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h5C;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = init_val(i);
            model_mem[i] = init_val(i);
        end
        env_mem[8'h10] = 8'hA5; model_mem[8'h10] = 8'hA5;
        env_mem[8'h11] = 8'h5A; model_mem[8'h11] = 8'h5A;
        env_mem[8'h01] = 8'hC1; model_mem[8'h01] = 8'hC1;
        env_mem[8'h02] = 8'hD2; model_mem[8'h02] = 8'hD2;
    end

    assign bus.mem_rdata = env_mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic item_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                                 input bit wig, input bit ab);
        item_t it;
        it.we = we; it.addr = a; it.wdata = d; it.wiggle = wig; it.abort = ab;
        return it;
    endfunction

    function automatic int qsize(input bit who);
        return who ? q_ld.size() : q_cpu.size();
    endfunction

    function automatic logic done_of(input bit who);
        return who ? bus.ld_done : bus.cpu_done;
    endfunction

    function automatic logic gnt_of(input bit who);
        return who ? bus.ld_gnt : bus.cpu_gnt;
    endfunction

    task automatic set_req(input bit who, input logic r, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (who) begin
            bus.ld_req = r; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
        end else begin
            bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    // Requester: holds req/operands until done, then drops req unless more work is queued.
    task automatic drive(input bit who);
        item_t it;
        bit got, aborted;
        int n;
        set_req(who, 1'b0, 1'b0, 8'h00, 8'h00);
        forever begin
            if (qsize(who) == 0) begin
                @(posedge clk); #1;
                continue;
            end
            if (who) it = q_ld.pop_front(); else it = q_cpu.pop_front();
            busy[who] = 1'b1;
            set_req(who, 1'b1, it.we, it.addr, it.wdata);
            a_cyc[who] = cyc;
            got = 1'b0; aborted = 1'b0; n = 0;
            while (!got && !aborted && n < 60) begin
                @(negedge clk); n++;
                if (CLR) aborted = 1'b1;
                else if (done_of(who)) begin
                    got = 1'b1;
                    d_cyc[who] = cyc;
                end else if (it.wiggle && bus.mem_rd && gnt_of(who)) begin
                    @(posedge clk); #1;
                    set_req(who, 1'b1, it.we, it.addr + 8'd1, it.wdata);
                end
            end
            check(who ? "ld_txn_end" : "cpu_txn_end", {30'd0, got, aborted},
                  it.abort ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            if (qsize(who) == 0) set_req(who, 1'b0, 1'b0, 8'h00, 8'h00);
            busy[who] = 1'b0;
        end
    endtask

    initial drive(1'b0);
    initial drive(1'b1);

    // Reference model: transaction offset from the sampling edge decides every output.
    always @(negedge clk) begin
        if (run_cmp) begin
            if (CLR) begin
                m_active = 1'b0; m_last = 1'b1;
                m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
            end
            e_rd = 0; e_xf = 0; e_we = 0; e_done = 0; e_addr = 8'h00; e_wdata = 8'h00;
            t = cyc - m_start;
            if (m_active) begin
                e_addr = m_addr; e_wdata = m_wdata;
                if (m_we) begin
                    e_we = (t == 1); e_done = (t == 2);
                end else begin
                    e_rd = (t == 1); e_xf = (t == 2); e_done = (t == 3);
                end
            end
            check("cpu_gnt",   bus.cpu_gnt,   m_active && !m_own);
            check("ld_gnt",    bus.ld_gnt,    m_active && m_own);
            check("cpu_done",  bus.cpu_done,  e_done && !m_own);
            check("ld_done",   bus.ld_done,   e_done && m_own);
            check("mem_rd",    bus.mem_rd,    e_rd);
            check("mem_xfer",  bus.mem_xfer,  e_xf);
            check("mem_we",    bus.mem_we,    e_we);
            check("mem_addr",  bus.mem_addr,  e_addr);
            check("mem_wdata", bus.mem_wdata, e_wdata);
            check("cpu_rdata", bus.cpu_rdata, m_rdata[0]);
            check("ld_rdata",  bus.ld_rdata,  m_rdata[1]);

            if (bus.cpu_done) done_log.push_back(1'b0);
            if (bus.ld_done)  done_log.push_back(1'b1);
            if (bus.ld_gnt)   ld_gnt_seen = 1'b1;
            if (bus.mem_we)   we_cycles++;

            if (m_active) begin
                if (e_xf) m_rdata[m_own] = model_mem[m_addr];
                if (e_done) begin
                    if (m_we) model_mem[m_addr] = m_wdata;
                    m_last = m_own;
                    m_active = 1'b0;
                end
            end else if (!CLR && (bus.cpu_req || bus.ld_req)) begin
                m_own = (bus.cpu_req && bus.ld_req) ? ~m_last : bus.ld_req;
                m_we    = m_own ? bus.ld_we    : bus.cpu_we;
                m_addr  = m_own ? bus.ld_addr  : bus.cpu_addr;
                m_wdata = m_own ? bus.ld_wdata : bus.cpu_wdata;
                m_start = cyc;
                m_active = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q_cpu.size() != 0 || q_ld.size() != 0 || busy[0] || busy[1]) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("idle_reached", {31'd0, n < 400}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base, n;
        logic [5:0] seq;
        CLR = 1'b1;
        #1 run_cmp = 1'b1;
        repeat (2) @(posedge clk);
        #1 CLR = 1'b0;
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_ld_rdata",  bus.ld_rdata,  8'h00);
        check("rst_mem_addr",  bus.mem_addr,  8'h00);

        // lone CPU read
        ld_gnt_seen = 1'b0;
        @(negedge clk); q_cpu.push_back(mk(1'b0, 8'h10, 8'h00, 1'b0, 1'b0));
        wait_idle();
        check("t1_latency",  d_cyc[0] - a_cyc[0], 3);
        check("t1_rdata",    bus.cpu_rdata, 8'hA5);
        check("t1_no_ldgnt", {31'd0, ld_gnt_seen}, 32'd0);

        // lone loader write
        we_cycles = 0;
        @(negedge clk); q_ld.push_back(mk(1'b1, 8'h20, 8'h3C, 1'b0, 1'b0));
        wait_idle();
        check("t2_latency",  d_cyc[1] - a_cyc[1], 2);
        check("t2_mem",      env_mem[8'h20], 8'h3C);
        check("t2_we_width", we_cycles, 1);
        check("t2_cpu_rd",   bus.cpu_rdata, 8'hA5);
        check("t2_ld_rd",    bus.ld_rdata,  8'h00);

        // first tie after reset
        @(posedge clk); #1 CLR = 1'b1;
        @(posedge clk); #1 CLR = 1'b0;
        check("t3_rst_rdata", bus.cpu_rdata, 8'h00);
        base = done_log.size();
        @(negedge clk);
        q_cpu.push_back(mk(1'b0, 8'h01, 8'h00, 1'b0, 1'b0));
        q_ld.push_back(mk(1'b0, 8'h02, 8'h00, 1'b0, 1'b0));
        wait_idle();
        check("t3_first_cpu", {31'd0, done_log[base]}, 32'd0);
        check("t3_ld_gap",    d_cyc[1] - d_cyc[0], 4);
        check("t3_cpu_rd",    bus.cpu_rdata, 8'hC1);
        check("t3_ld_rd",     bus.ld_rdata,  8'hD2);

        // continuous contention alternates
        base = done_log.size();
        @(negedge clk);
        q_cpu.push_back(mk(1'b0, 8'h40, 8'h00, 1'b0, 1'b0));
        q_cpu.push_back(mk(1'b1, 8'h41, 8'h77, 1'b0, 1'b0));
        q_cpu.push_back(mk(1'b0, 8'h41, 8'h00, 1'b0, 1'b0));
        q_ld.push_back(mk(1'b1, 8'h42, 8'h88, 1'b0, 1'b0));
        q_ld.push_back(mk(1'b0, 8'h40, 8'h00, 1'b0, 1'b0));
        q_ld.push_back(mk(1'b0, 8'h42, 8'h00, 1'b0, 1'b0));
        wait_idle();
        check("t4_count", done_log.size() - base, 6);
        seq = '0;
        for (int i = 0; i < 6 && base + i < done_log.size(); i++) seq[i] = done_log[base + i];
        check("t4_order",  seq, 6'b101010);
        check("t4_cpu_rd", bus.cpu_rdata, 8'h77);
        check("t4_ld_rd",  bus.ld_rdata,  8'h88);

        // reset during a loader write
        base = done_log.size();
        @(negedge clk); q_ld.push_back(mk(1'b1, 8'h30, 8'h99, 1'b0, 1'b1));
        n = 0;
        while (!bus.mem_we && n < 20) begin @(negedge clk); n++; end
        check("t5_wr_seen", bus.mem_we, 1'b1);
        #2 CLR = 1'b1;
        #1;
        check("t5_we_drop",  bus.mem_we, 1'b0);
        check("t5_gnt_drop", bus.ld_gnt, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 CLR = 1'b0;
        wait_idle();
        check("t5_no_done", done_log.size() - base, 0);
        check("t5_mem",     env_mem[8'h30], init_val(8'h30));
        base = done_log.size();
        @(negedge clk);
        q_cpu.push_back(mk(1'b0, 8'h01, 8'h00, 1'b0, 1'b0));
        q_ld.push_back(mk(1'b0, 8'h02, 8'h00, 1'b0, 1'b0));
        wait_idle();
        check("t5_tie_cpu", {31'd0, done_log[base]}, 32'd0);

        // operand change after latching
        @(negedge clk); q_cpu.push_back(mk(1'b0, 8'h10, 8'h00, 1'b1, 1'b0));
        wait_idle();
        check("t6_rdata",   bus.cpu_rdata, 8'hA5);
        check("t6_latency", d_cyc[0] - a_cyc[0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
